// File: rtl/fwd_hazard_unit_n_if.sv
// Operand/stage bus between the ID-stage pipeline control and the forwarding/hazard unit.
// The pipeline side is the master; the unit is the slave.
interface fwd_hazard_unit_n_if #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 3,
  parameter int NUM_STG = 3,
  parameter int CNT_W   = 16
);
  localparam int SEL_W = $clog2(NUM_STG + 1);

  logic                       fwd_en;
  logic                       flush;
  logic [NUM_SRC*REG_AW-1:0]  src_addr;
  logic [NUM_SRC-1:0]         src_vld;
  logic [NUM_STG*REG_AW-1:0]  stg_dest;
  logic [NUM_STG-1:0]         stg_wb_en;
  logic [NUM_STG-1:0]         stg_mem_r_en;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic                       stall;
  logic [CNT_W-1:0]           stall_cnt;

  modport master (
    output fwd_en, flush, src_addr, src_vld, stg_dest, stg_wb_en, stg_mem_r_en,
    input  fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  fwd_en, flush, src_addr, src_vld, stg_dest, stg_wb_en, stg_mem_r_en,
    output fwd_sel, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit_n.sv
// Forwarding + hazard unit: per-operand bypass selects (nearest producer wins) and a
// pipeline stall, with a small FSM that stretches load-use stalls to LOAD_LAT cycles.
//   state | meaning
//   IDLE  | stall follows the combinational hazard
//   HOLD  | load-use stall in progress, hold_cnt cycles left
module fwd_hazard_unit_n #(
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 3,
  parameter int NUM_STG  = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  fwd_hazard_unit_n_if.slave hz
);
  localparam int SEL_W  = $clog2(NUM_STG + 1);
  localparam int HOLD_W = $clog2(LOAD_LAT + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [HOLD_W-1:0]        hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     hazard;
  logic                     load_use;
  logic                     stall;

  // A load in the winning stage blocks the bypass; older stages never get a look-in.
  always_comb begin : match_p
    logic hit;
    hit      = 1'b0;
    fwd_sel  = '0;
    hazard   = 1'b0;
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit = 1'b0;
      for (int k = 0; k < NUM_STG; k++) begin
        if (!hit && hz.src_vld[i] && hz.stg_wb_en[k] &&
            (hz.stg_dest[k*REG_AW +: REG_AW] == hz.src_addr[i*REG_AW +: REG_AW])) begin
          hit = 1'b1;
          if (!hz.fwd_en) begin
            hazard = 1'b1;
          end else if (hz.stg_mem_r_en[k]) begin
            hazard   = 1'b1;
            load_use = 1'b1;
          end else begin
            fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          end
        end
      end
    end
  end

  always_comb begin : fsm_p
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    stall       = 1'b0;
    if (hz.flush) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          stall = hazard;
          if (load_use && (LOAD_LAT > 1)) begin
            state_d    = HOLD;
            hold_cnt_d = HOLD_W'(LOAD_LAT - 1);
          end
        end
        HOLD: begin
          stall      = 1'b1;
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          if (hold_cnt_q == HOLD_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.fwd_sel   = fwd_sel;
  assign hz.stall     = stall;
  assign hz.stall_cnt = stall_cnt_q;
endmodule
